// File: rtl/bram_seq_ctrl.sv
// Loads one frame of DEPTH samples into an external BRAM, then replays it from a latched offset.
// Optional macro BRAM_SEQ_REVERSE_EN adds read_dir for descending playback.
module bram_seq_ctrl #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int DATA_W = 4
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              load_req,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              start,
  input  logic [ADDR_W-1:0] delay,
`ifdef BRAM_SEQ_REVERSE_EN
  input  logic              read_dir,
`endif
  output logic              ram_wren,
  output logic [ADDR_W-1:0] ram_wraddr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_rden,
  output logic [ADDR_W-1:0] ram_rdaddr,
  input  logic [DATA_W-1:0] ram_q,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              loaded,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, LOAD, READY, READ} state_t;

  localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   DRAIN_END = (ADDR_W+1)'(DEPTH + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [ADDR_W:0]   rd_cnt_q, rd_cnt_d;
  logic [ADDR_W-1:0] delay_q, delay_d;
  logic              loaded_q, loaded_d;
  logic              out_valid_q;
`ifdef BRAM_SEQ_REVERSE_EN
  logic              dir_q, dir_d;
`endif

  logic [ADDR_W-1:0] k;
  logic [ADDR_W:0]   fwd_sum;
  logic [ADDR_W-1:0] rd_addr;

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      delay_q     <= '0;
      loaded_q    <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef BRAM_SEQ_REVERSE_EN
      dir_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      delay_q     <= delay_d;
      loaded_q    <= loaded_d;
      out_valid_q <= ram_rden;
`ifdef BRAM_SEQ_REVERSE_EN
      dir_q       <= dir_d;
`endif
    end
  end

  // READ keeps counting past DEPTH for two drain cycles: the last out_valid, then done.
  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    delay_d  = delay_q;
    loaded_d = loaded_q;
    ram_wren = 1'b0;
    ram_rden = 1'b0;
    done     = 1'b0;
`ifdef BRAM_SEQ_REVERSE_EN
    dir_d    = dir_q;
`endif
    case (state_q)
      IDLE: begin
        if (load_req) begin
          state_d  = LOAD;
          wr_cnt_d = '0;
        end
      end
      LOAD: begin
        if (sample_valid) begin
          ram_wren = 1'b1;
          if (wr_cnt_q == LAST_ADDR) begin
            state_d  = READY;
            wr_cnt_d = '0;
            loaded_d = 1'b1;
          end else begin
            wr_cnt_d = wr_cnt_q + 1'b1;
          end
        end
      end
      READY: begin
        if (load_req) begin
          state_d  = LOAD;
          loaded_d = 1'b0;
          wr_cnt_d = '0;
        end else if (start) begin
          state_d  = READ;
          delay_d  = delay;
          rd_cnt_d = '0;
`ifdef BRAM_SEQ_REVERSE_EN
          dir_d    = read_dir;
`endif
        end
      end
      READ: begin
        ram_rden = (rd_cnt_q < DEPTH_C);
        if (rd_cnt_q == DRAIN_END) begin
          done     = 1'b1;
          state_d  = READY;
          rd_cnt_d = '0;
        end else begin
          rd_cnt_d = rd_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Modulo-DEPTH offset arithmetic so non-power-of-two depths wrap correctly.
  always_comb begin
    k       = rd_cnt_q[ADDR_W-1:0];
    fwd_sum = {1'b0, delay_q} + {1'b0, k};
    rd_addr = (fwd_sum >= DEPTH_C) ? ADDR_W'(fwd_sum - DEPTH_C) : ADDR_W'(fwd_sum);
`ifdef BRAM_SEQ_REVERSE_EN
    if (dir_q) begin
      rd_addr = (delay_q >= k) ? (delay_q - k)
                               : ADDR_W'({1'b0, delay_q} + DEPTH_C - {1'b0, k});
    end
`endif
  end

  assign ram_rdaddr = ram_rden ? rd_addr : '0;
  assign ram_wraddr = wr_cnt_q;
  assign ram_data   = sample_in;
  assign out_data   = ram_q;
  assign out_valid  = out_valid_q;
  assign loaded     = loaded_q;
  assign busy       = (state_q == LOAD) || (state_q == READ);

endmodule

// File: tb/tb_bram_seq_ctrl.sv
// Scoreboard bench for bram_seq_ctrl: stimulus pushes expected RAM traffic, a negedge monitor pops and compares.
module tb_bram_seq_ctrl;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;
  localparam int DATA_W = 4;

  logic              clock = 1'b0;
  logic              rst;
  logic              load_req, sample_valid, start;
  logic [DATA_W-1:0] sample_in;
  logic [ADDR_W-1:0] delay;
  logic              read_dir;
  logic              ram_wren, ram_rden, out_valid, loaded, busy, done;
  logic [ADDR_W-1:0] ram_wraddr, ram_rdaddr;
  logic [DATA_W-1:0] ram_data, ram_q, out_data;

  logic [DATA_W-1:0] mem [DEPTH];
  int ref_frame [DEPTH];
  bit model_loaded;

  int wr_addr_q[$], wr_data_q[$], rd_q[$], dat_q[$], done_q[$];
  int vectors = 0;
  int miscompares = 0;
  int rd_seen = 0;
  bit last_ov = 1'b0;

  bram_seq_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock(clock), .rst(rst), .load_req(load_req), .sample_valid(sample_valid),
    .sample_in(sample_in), .start(start), .delay(delay),
`ifdef BRAM_SEQ_REVERSE_EN
    .read_dir(read_dir),
`endif
    .ram_wren(ram_wren), .ram_wraddr(ram_wraddr), .ram_data(ram_data),
    .ram_rden(ram_rden), .ram_rdaddr(ram_rdaddr), .ram_q(ram_q),
    .out_data(out_data), .out_valid(out_valid), .loaded(loaded),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  // Behavioural synchronous RAM with one cycle of read latency.
  always @(posedge clock) begin
    if (ram_wren) mem[ram_wraddr] <= ram_data;
    if (ram_rden) ram_q <= mem[ram_rdaddr];
  end

  task automatic check_output(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every DUT-presented event must match the head of its queue.
  always @(negedge clock) begin
    if (ram_wren && ram_rden) check_output("wren_rden_exclusive", 1, 0);
    if (ram_wren) begin
      if (wr_addr_q.size() == 0) check_output("unexpected_write", 1, 0);
      else begin
        check_output("wraddr", int'(ram_wraddr), wr_addr_q.pop_front());
        check_output("wrdata", int'(ram_data), wr_data_q.pop_front());
      end
    end
    if (ram_rden) begin
      rd_seen++;
      if (rd_q.size() == 0) check_output("unexpected_read", 1, 0);
      else check_output("rdaddr", int'(ram_rdaddr), rd_q.pop_front());
    end
    if (out_valid) begin
      if (dat_q.size() == 0) check_output("unexpected_out_valid", 1, 0);
      else check_output("out_data", int'(out_data), dat_q.pop_front());
    end
    if (done) begin
      if (done_q.size() == 0) check_output("unexpected_done", 1, 0);
      else begin
        void'(done_q.pop_front());
        check_output("done_after_last_valid", int'(last_ov && !out_valid && dat_q.size() == 0), 1);
      end
    end
    last_ov = out_valid;
  end

  task automatic apply_load(input bit send_req, input bit ramp, input bit fixed_gap);
    if (send_req) begin
      @(posedge clock); #1 load_req = 1'b1;
      @(posedge clock); #1 load_req = 1'b0;
    end
    model_loaded = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      int gaps, val;
      gaps = fixed_gap ? (i == 0 ? 0 : 1) : int'($urandom_range(0, 2));
      for (int g = 0; g < gaps; g++) begin
        sample_valid = 1'b0; load_req = 1'b1; start = 1'b1;
        sample_in = DATA_W'($urandom);
        @(posedge clock); #1;
      end
      load_req = 1'b0; start = 1'b0;
      val = ramp ? i + 1 : int'($urandom_range(0, (1 << DATA_W) - 1));
      sample_valid = 1'b1; sample_in = DATA_W'(val);
      ref_frame[i] = val;
      wr_addr_q.push_back(i);
      wr_data_q.push_back(val);
      @(posedge clock); #1;
    end
    sample_valid = 1'b0;
    model_loaded = 1'b1;
    check_output("loaded_after_frame", int'(loaded), 1);
  endtask

  task automatic push_frame(input int d, input bit dir);
    for (int k = 0; k < DEPTH; k++) begin
      int a;
      a = dir ? (d - k + DEPTH) % DEPTH : (d + k) % DEPTH;
      rd_q.push_back(a);
      dat_q.push_back(ref_frame[a]);
    end
    done_q.push_back(1);
  endtask

  task automatic wait_drained();
    int n = 0;
    while ((rd_q.size() != 0 || dat_q.size() != 0 || done_q.size() != 0) && n < 40) begin
      @(posedge clock); n++;
    end
    #1;
    check_output("frame_completed_in_time", int'(n < 40), 1);
    if (n >= 40) begin
      rd_q.delete(); dat_q.delete(); done_q.delete();
    end
  endtask

  task automatic apply_start(input int d, input bit dir, input bit disturb);
    @(posedge clock); #1 start = 1'b1; delay = ADDR_W'(d); read_dir = dir;
    if (model_loaded) push_frame(d, dir);
    @(posedge clock); #1 start = 1'b0;
    if (disturb) begin
      for (int c = 0; c < 3; c++) begin
        start = 1'b1; load_req = 1'b1; delay = ADDR_W'($urandom); read_dir = ~dir;
        @(posedge clock); #1;
      end
      start = 1'b0; load_req = 1'b0;
    end
    if (model_loaded) begin
      wait_drained();
      check_output("idle_after_play_busy", int'(busy), 0);
      check_output("loaded_after_play", int'(loaded), 1);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_wren"}, int'(ram_wren), 0);
    check_output({tag, "_rden"}, int'(ram_rden), 0);
    check_output({tag, "_out_valid"}, int'(out_valid), 0);
    check_output({tag, "_done"}, int'(done), 0);
    check_output({tag, "_loaded"}, int'(loaded), 0);
    check_output({tag, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    rst = 1'b0; load_req = 1'b0; sample_valid = 1'b0; start = 1'b0;
    sample_in = '0; delay = '0; read_dir = 1'b0; model_loaded = 1'b0;
    #1 check_all_zero("reset");
    #12 rst = 1'b1;

    // Start in IDLE must not read anything.
    apply_start(3, 1'b0, 1'b0);
    repeat (12) @(posedge clock);
    #1 check_output("idle_start_ignored_busy", int'(busy), 0);

    // Gapped ramp load, then play from offset 5 with disturbances during READ.
    apply_load(1'b1, 1'b1, 1'b1);
    apply_start(5, 1'b0, 1'b1);
    apply_start(5, 1'b0, 1'b0);

    // load_req and start together in READY: load wins, no reads.
    @(posedge clock); #1 load_req = 1'b1; start = 1'b1; delay = 3;
    @(posedge clock); #1 load_req = 1'b0; start = 1'b0;
    model_loaded = 1'b0;
    check_output("load_wins_busy", int'(busy), 1);
    check_output("load_wins_loaded", int'(loaded), 0);
    apply_load(1'b0, 1'b0, 1'b0);

`ifdef BRAM_SEQ_REVERSE_EN
    apply_start(2, 1'b1, 1'b0);
`endif

    // Randomised loads and replays.
    for (int it = 0; it < 4; it++) begin
      apply_load(1'b1, 1'b0, 1'b0);
      for (int p = 0; p < 2; p++) begin
        bit dir;
`ifdef BRAM_SEQ_REVERSE_EN
        dir = 1'($urandom);
`else
        dir = 1'b0;
`endif
        apply_start(int'($urandom_range(0, DEPTH - 1)), dir, 1'($urandom));
      end
    end

    // Asynchronous reset at the 4th read cycle aborts playback.
    begin
      int base, n;
      apply_load(1'b1, 1'b1, 1'b0);
      @(posedge clock); #1 start = 1'b1; delay = 1; read_dir = 1'b0;
      push_frame(1, 1'b0);
      base = rd_seen;
      @(posedge clock); #1 start = 1'b0;
      n = 0;
      while (rd_seen - base < 3 && n < 20) begin
        @(posedge clock); n++;
      end
      check_output("reads_before_reset", rd_seen - base, 3);
      #2 rst = 1'b0;
      #1 check_all_zero("async_reset");
      rd_q.delete(); dat_q.delete(); done_q.delete();
      model_loaded = 1'b0;
      @(negedge clock); #1 rst = 1'b1;
      apply_start(4, 1'b0, 1'b0);
      repeat (14) @(posedge clock);
      #1 check_output("start_after_reset_ignored", int'(busy), 0);
      apply_load(1'b1, 1'b0, 1'b0);
      apply_start(6, 1'b0, 1'b0);
    end

    repeat (4) @(posedge clock);
    #1;
    check_output("pending_writes", wr_addr_q.size(), 0);
    check_output("pending_reads", rd_q.size() + dat_q.size() + done_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule

// File: doc/bram_seq_ctrl.md
BRAM_SEQ_CTRL -- requirements
Module: bram_seq_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning the number of RAM entries sequenced per frame.
REQ-002 SHALL have parameter ADDR_W, default 3, meaning the RAM address width, log2(DEPTH).
REQ-003 SHALL have parameter DATA_W, default 4, meaning the sample width.
REQ-004 SHALL have port clock  input  1  single system clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port load_req  input  1  request to begin loading a frame.
REQ-007 SHALL have port sample_valid  input  1  sample_in is valid this cycle.
REQ-008 SHALL have port sample_in  input  DATA_W  sample to be written.
REQ-009 SHALL have port start  input  1  request to play out the loaded frame.
REQ-010 SHALL have port delay  input  ADDR_W  read start offset, sampled on an accepted start.
REQ-011 SHALL have port ram_wren  output  1  RAM write enable.
REQ-012 SHALL have port ram_wraddr  output  ADDR_W  RAM write address.
REQ-013 SHALL have port ram_data  output  DATA_W  RAM write data, equal to sample_in.
REQ-014 SHALL have port ram_rden  output  1  RAM read enable.
REQ-015 SHALL have port ram_rdaddr  output  ADDR_W  RAM read address.
REQ-016 SHALL have port ram_q  input  DATA_W  RAM read data, valid 1 cycle after ram_rden.
REQ-017 SHALL have port out_data  output  DATA_W  played-out sample, equal to ram_q.
REQ-018 SHALL have port out_valid  output  1  out_data is valid this cycle.
REQ-019 SHALL have port loaded  output  1  a complete frame is held in RAM.
REQ-020 SHALL have port busy  output  1  high in LOAD or READ.
REQ-021 SHALL have port done  output  1  single-cycle pulse after the last out_valid of a frame.

Function
REQ-022 SHALL implement the states IDLE, LOAD, READY and READ.
REQ-023 IDLE SHALL move to LOAD on load_req; start SHALL be ignored in IDLE.
REQ-024 In LOAD, each cycle with sample_valid high SHALL assert ram_wren combinationally, with ram_wraddr = write counter; the counter SHALL then increment.
REQ-025 In LOAD, cycles with sample_valid low SHALL write nothing, and the counter SHALL hold.
REQ-026 The write with counter = DEPTH-1 SHALL move the FSM to READY, clear the counter to 0 and set loaded=1.
REQ-027 In READY, load_req SHALL move the FSM to LOAD with loaded=0; start SHALL latch delay and move the FSM to READ.
REQ-028 If load_req and start are high together in READY, load_req SHALL win and start SHALL be dropped.
REQ-029 In READ, ram_rden SHALL be high for exactly DEPTH consecutive cycles, with ram_rdaddr = (delay_latched + k) mod DEPTH for k = 0..DEPTH-1, wrapping with no gap.
REQ-030 out_valid SHALL equal ram_rden delayed by 1 cycle.
REQ-031 done SHALL pulse in the cycle after the final out_valid, and the FSM SHALL then return to READY with loaded remaining 1.
REQ-032 The frame SHALL be replayable any number of times without reloading.
REQ-033 load_req and start SHALL be ignored while busy=1.
REQ-034 ram_wren and ram_rden SHALL never be high in the same cycle.

Reset
REQ-035 rst=0 SHALL immediately force: FSM to IDLE, counters to 0, delay_latched to 0, ram_wren=0, ram_rden=0, out_valid=0, done=0, loaded=0, busy=0.
REQ-036 Reset in mid-LOAD or mid-READ SHALL abort the operation, and no further RAM access SHALL occur until a new load_req.
REQ-037 After rst deassertion, the first state change SHALL occur at the next rising clock edge.

Configuration
REQ-038 Macro BRAM_SEQ_REVERSE_EN, when defined, SHALL add the input port read_dir (1 bit), sampled together with delay on an accepted start.
REQ-039 With BRAM_SEQ_REVERSE_EN defined and read_dir=1, ram_rdaddr SHALL be (delay_latched - k) mod DEPTH; with read_dir=0, it SHALL be per REQ-029.
REQ-040 With BRAM_SEQ_REVERSE_EN undefined, the port read_dir SHALL be absent and the read order SHALL always be ascending.

Verification
REQ-041 Bench: load_req, then 8 valid samples 1..8 with sample_valid gapped every 2nd cycle -> wraddr 0..7 written only on valid cycles; loaded=1 after the 8th write.
REQ-042 Bench: start with delay=5 -> rdaddr 5,6,7,0,1,2,3,4; out_data 6,7,8,1,2,3,4,5; done pulses 1 cycle after the last out_valid.
REQ-043 Bench: start in IDLE -> no ram_rden; load_req and start together in READY -> enters LOAD, no reads.
REQ-044 Bench: start during READ and load_req during LOAD -> ignored; sequence unchanged.
REQ-045 Bench: rst=0 at the 4th read cycle -> all outputs 0 asynchronously; the next start is ignored until a reload completes.
REQ-046 Bench: BRAM_SEQ_REVERSE_EN defined, read_dir=1, delay=2 -> rdaddr 2,1,0,7,6,5,4,3.
